// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a dual 4-to-1 selector: steps select 0..3 with active-low strobes,
// samples 1Y/2Y after a settle delay and delivers two 4-bit words with a valid pulse.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       in_CLK,
    input  logic       in_RSTn,
    input  logic       in_START,
    input  logic       in_ABORT,
    input  logic       in_1Y,
    input  logic       in_2Y,
    output logic       out_A,
    output logic       out_B,
    output logic       out_G1,
    output logic       out_G2,
    output logic [3:0] out_WORD1,
    output logic [3:0] out_WORD2,
    output logic       out_VALID,
    output logic       out_BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // With no settle time every select change goes straight to sampling.
    localparam state_t     LP_AFTER_SEL = (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;
    localparam logic [3:0] LP_LAST_CNT  = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

    state_t     r_state, w_state_nx;
    logic [1:0] r_idx,   w_idx_nx;
    logic [3:0] r_cnt,   w_cnt_nx;
    logic [2:0] r_sh1,   w_sh1_nx;
    logic [2:0] r_sh2,   w_sh2_nx;
    logic [3:0] r_word1, w_word1_nx;
    logic [3:0] r_word2, w_word2_nx;
    logic       r_g,     w_g_nx;
    logic       r_valid, w_valid_nx;
    logic       r_busy,  w_busy_nx;

    always_ff @(posedge in_CLK or negedge in_RSTn) begin
        if (!in_RSTn) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_sh1   <= '0;
            r_sh2   <= '0;
            r_word1 <= '0;
            r_word2 <= '0;
            r_g     <= 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_cnt_nx;
            r_sh1   <= w_sh1_nx;
            r_sh2   <= w_sh2_nx;
            r_word1 <= w_word1_nx;
            r_word2 <= w_word2_nx;
            r_g     <= w_g_nx;
            r_valid <= w_valid_nx;
            r_busy  <= w_busy_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt;
        w_sh1_nx   = r_sh1;
        w_sh2_nx   = r_sh2;
        w_word1_nx = r_word1;
        w_word2_nx = r_word2;
        w_g_nx     = r_g;
        w_valid_nx = 1'b0;
        w_busy_nx  = r_busy;

        case (r_state)
            ST_IDLE: begin
                w_idx_nx  = '0;
                w_g_nx    = 1'b1;
                w_busy_nx = 1'b0;
                if (in_START) begin
                    w_cnt_nx   = '0;
                    w_g_nx     = 1'b0;
                    w_busy_nx  = 1'b1;
                    w_state_nx = LP_AFTER_SEL;
                end
            end
            ST_SETTLE: begin
                if (in_ABORT) begin
                    w_state_nx = ST_IDLE;
                    w_idx_nx   = '0;
                    w_cnt_nx   = '0;
                    w_g_nx     = 1'b1;
                    w_busy_nx  = 1'b0;
                end else if (r_cnt == LP_LAST_CNT) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_SAMPLE;
                end else begin
                    w_cnt_nx = r_cnt + 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (in_ABORT) begin
                    w_state_nx = ST_IDLE;
                    w_idx_nx   = '0;
                    w_cnt_nx   = '0;
                    w_g_nx     = 1'b1;
                    w_busy_nx  = 1'b0;
                end else if (r_idx == 2'd3) begin
                    // Last bit goes straight into the word so the shadow never leaks a partial result.
                    w_word1_nx = {in_1Y, r_sh1};
                    w_word2_nx = {in_2Y, r_sh2};
                    w_valid_nx = 1'b1;
                    w_g_nx     = 1'b1;
                    w_idx_nx   = '0;
                    w_state_nx = ST_DONE;
                end else begin
                    for (int unsigned i = 0; i < 3; i++) begin
                        if (r_idx == 2'(i)) begin
                            w_sh1_nx[i] = in_1Y;
                            w_sh2_nx[i] = in_2Y;
                        end
                    end
                    w_idx_nx   = r_idx + 2'd1;
                    w_cnt_nx   = '0;
                    w_state_nx = LP_AFTER_SEL;
                end
            end
            ST_DONE: begin
                w_busy_nx  = 1'b0;
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign out_A     = r_idx[1];
    assign out_B     = r_idx[0];
    assign out_G1    = r_g;
    assign out_G2    = r_g;
    assign out_WORD1 = r_word1;
    assign out_WORD2 = r_word2;
    assign out_VALID = r_valid;
    assign out_BUSY  = r_busy;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: two instances (SETTLE_CYC = 1 and 0) each wrapped
// by a behavioural '153 selector model fed from bench-owned data nibbles.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, abort1, start0, abort0;
    logic [3:0] c_data, d_data;

    logic       a1, b1, g1_1, g2_1, valid1, busy1;
    logic [3:0] w1_1, w2_1;
    logic       a0, b0, g1_0, g2_0, valid0, busy0;
    logic [3:0] w1_0, w2_0;
    logic       y1_1, y2_1, y1_0, y2_0;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // Selector model: enabled section passes the selected data bit, disabled section drives 0.
    assign y1_1 = !g1_1 ? c_data[{a1, b1}] : 1'b0;
    assign y2_1 = !g2_1 ? d_data[{a1, b1}] : 1'b0;
    assign y1_0 = !g1_0 ? c_data[{a0, b0}] : 1'b0;
    assign y2_0 = !g2_0 ? d_data[{a0, b0}] : 1'b0;

    wire [5:0] obs1  = {a1, b1, g1_1, g2_1, busy1, valid1};
    wire [5:0] obs0  = {a0, b0, g1_0, g2_0, busy0, valid0};
    wire [7:0] word1 = {w1_1, w2_1};
    wire [7:0] word0 = {w1_0, w2_0};

    localparam logic [5:0] IDLE_ST = 6'b00_11_00;
    localparam logic [5:0] DONE_ST = 6'b00_11_11;

    mux_scan_ctrl #(.SETTLE_CYC(1)) dut (
        .in_CLK(clk), .in_RSTn(rst_n), .in_START(start1), .in_ABORT(abort1),
        .in_1Y(y1_1), .in_2Y(y2_1), .out_A(a1), .out_B(b1), .out_G1(g1_1), .out_G2(g2_1),
        .out_WORD1(w1_1), .out_WORD2(w2_1), .out_VALID(valid1), .out_BUSY(busy1)
    );

    mux_scan_ctrl #(.SETTLE_CYC(0)) dut0 (
        .in_CLK(clk), .in_RSTn(rst_n), .in_START(start0), .in_ABORT(abort0),
        .in_1Y(y1_0), .in_2Y(y2_0), .out_A(a0), .out_B(b0), .out_G1(g1_0), .out_G2(g2_0),
        .out_WORD1(w1_0), .out_WORD2(w2_0), .out_VALID(valid0), .out_BUSY(busy0)
    );

    // Scanning status after edge k of a SETTLE_CYC=1 scan (k = 0..7).
    function automatic logic [5:0] scan_st1(input int k);
        logic [1:0] s;
        s = 2'(k / 2);
        return {s, 2'b00, 1'b1, 1'b0};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start1 = 0; abort1 = 0; start0 = 0; abort0 = 0;
        c_data = 4'h0; d_data = 4'h0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({obs1, word1} !== {IDLE_ST, 8'h00})
            $display("FAIL reset_dut1: got %b/%h expected %b/00", obs1, word1, IDLE_ST);
        else pass_cnt++;
        total_cnt++;
        if ({obs0, word0} !== {IDLE_ST, 8'h00})
            $display("FAIL reset_dut0: got %b/%h expected %b/00", obs0, word0, IDLE_ST);
        else pass_cnt++;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({obs1, word1, obs0, word0} !== {IDLE_ST, 8'h00, IDLE_ST, 8'h00})
                $display("FAIL idle_hold cyc %0d: got %b/%h %b/%h expected %b/00 both",
                         k, obs1, word1, obs0, word0, IDLE_ST);
            else pass_cnt++;
        end
    endtask

    task automatic test_basic();
        logic [5:0] e;
        logic [7:0] ew;
        c_data = 4'b1010; d_data = 4'b0110;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(negedge clk);
            e  = (k < 8) ? scan_st1(k) : (k == 8) ? DONE_ST : IDLE_ST;
            ew = (k >= 8) ? 8'hA6 : 8'h00;
            total_cnt++;
            if ({obs1, word1} !== {e, ew})
                $display("FAIL basic edge %0d: got %b/%h expected %b/%h", k, obs1, word1, e, ew);
            else pass_cnt++;
        end
    endtask

    task automatic test_settle0();
        logic [5:0] e;
        logic [7:0] ew;
        c_data = 4'b0001; d_data = 4'b1111;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            e  = (k < 4) ? {2'(k), 2'b00, 1'b1, 1'b0} : (k == 4) ? DONE_ST : IDLE_ST;
            ew = (k >= 4) ? 8'h1F : 8'h00;
            total_cnt++;
            if ({obs0, word0} !== {e, ew})
                $display("FAIL settle0 edge %0d: got %b/%h expected %b/%h", k, obs0, word0, e, ew);
            else pass_cnt++;
        end
    endtask

    task automatic test_abort();
        c_data = 4'hF; d_data = 4'h0;
        // Abort during SETTLE with idx = 2 (after edge 4).
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (obs1 !== scan_st1(4))
            $display("FAIL abort_pre idx2: got %b expected %b", obs1, scan_st1(4));
        else pass_cnt++;
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        total_cnt++;
        if ({obs1, word1} !== {IDLE_ST, 8'hA6})
            $display("FAIL abort_idx2: got %b/%h expected %b/a6", obs1, word1, IDLE_ST);
        else pass_cnt++;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({obs1, word1} !== {IDLE_ST, 8'hA6})
                $display("FAIL abort_quiet cyc %0d: got %b/%h expected %b/a6", k, obs1, word1, IDLE_ST);
            else pass_cnt++;
        end
        // Abort coinciding with the final sample (SAMPLE, idx = 3, after edge 7).
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (7) @(negedge clk);
        total_cnt++;
        if (obs1 !== scan_st1(7))
            $display("FAIL abort_pre idx3: got %b expected %b", obs1, scan_st1(7));
        else pass_cnt++;
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        total_cnt++;
        if ({obs1, word1} !== {IDLE_ST, 8'hA6})
            $display("FAIL abort_final: got %b/%h expected %b/a6", obs1, word1, IDLE_ST);
        else pass_cnt++;
        // START and ABORT together in IDLE: START wins.
        @(negedge clk);
        start1 = 1'b1; abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; abort1 = 1'b0;
        total_cnt++;
        if (obs1 !== scan_st1(0))
            $display("FAIL start_abort_idle: got %b expected %b", obs1, scan_st1(0));
        else pass_cnt++;
        repeat (8) @(negedge clk);
        total_cnt++;
        if ({obs1, word1} !== {DONE_ST, 8'hF0})
            $display("FAIL start_abort_done: got %b/%h expected %b/f0", obs1, word1, DONE_ST);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int gap;
        c_data = 4'h5; d_data = 4'h6;
        start1 = 1'b1;
        @(negedge clk);
        repeat (8) @(negedge clk);
        total_cnt++;
        if ({obs1, word1} !== {DONE_ST, 8'h56})
            $display("FAIL b2b_first: got %b/%h expected %b/56", obs1, word1, DONE_ST);
        else pass_cnt++;
        c_data = 4'h3;
        gap = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) begin
                total_cnt++;
                if (obs1 !== IDLE_ST)
                    $display("FAIL b2b_done_ignores_start: got %b expected %b", obs1, IDLE_ST);
                else pass_cnt++;
            end
            if (valid1 === 1'b1) begin
                gap = n;
                break;
            end
        end
        total_cnt++;
        if (gap !== 10)
            $display("FAIL b2b_gap: got %0d cycles expected 10", gap);
        else pass_cnt++;
        total_cnt++;
        if (word1 !== 8'h36)
            $display("FAIL b2b_second_word: got %h expected 36", word1);
        else pass_cnt++;
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (obs1 !== IDLE_ST)
            $display("FAIL b2b_stop: got %b expected %b", obs1, IDLE_ST);
        else pass_cnt++;
    endtask

    task automatic test_reset_midscan();
        c_data = 4'h9; d_data = 4'h2;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (6) @(negedge clk);
        total_cnt++;
        if (obs1 !== scan_st1(6))
            $display("FAIL rst_mid_pre: got %b expected %b", obs1, scan_st1(6));
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({obs1, word1} !== {IDLE_ST, 8'h00})
            $display("FAIL rst_mid_immediate: got %b/%h expected %b/00", obs1, word1, IDLE_ST);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({obs1, word1} !== {IDLE_ST, 8'h00})
                $display("FAIL rst_mid_quiet cyc %0d: got %b/%h expected %b/00", k, obs1, word1, IDLE_ST);
            else pass_cnt++;
        end
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (8) @(negedge clk);
        total_cnt++;
        if ({obs1, word1} !== {DONE_ST, 8'h92})
            $display("FAIL rst_mid_rescan: got %b/%h expected %b/92", obs1, word1, DONE_ST);
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_settle0();
        test_abort();
        test_back_to_back();
        test_reset_midscan();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
